// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end with a prefetch FIFO.
// Issues sequential reads to instruction memory, tags each accepted request
// with its PC, and queues the returned {instruction, PC} pairs so decode stalls
// do not stall fetch. A redirect flushes all wrong-path state and restarts
// fetch at the target PC.
// Optional build macro FETCH_STATS_EN adds two 32-bit saturating counters
// (accepted requests, discarded words); without it both counter outputs are 0.
module fetch_prefetch_queue #(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INST_W   = 16,
  parameter int unsigned        QDEPTH   = 4,
  parameter int unsigned        PC_STEP  = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_rd,
  input  logic              i_imem_wait,
  input  logic [INST_W-1:0] i_imem_rddata,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_flush_cnt
);

  localparam int unsigned       PTR_W     = $clog2(QDEPTH);
  localparam int unsigned       CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  QDEPTH_C  = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP_C = ADDR_W'(PC_STEP);

  // Fetch-side state
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] tag_r;
  logic              inflight_r;

  // Queue storage and bookkeeping
  logic [INST_W-1:0] inst_mem_r [QDEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Per-cycle decisions
  logic [CNT_W-1:0]  credit_s;
  logic              issue_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  // Issue/accept/push/pop decisions; redirect overrides push and pop, and a
  // pop in this cycle never frees a credit for a request in this cycle.
  always_comb begin
    credit_s = count_r + {{(CNT_W-1){1'b0}}, inflight_r};
    if (reset || i_halt || i_redirect) begin
      issue_s = 1'b0;
    end else begin
      issue_s = (credit_s < QDEPTH_C);
    end
    accept_s = issue_s && !i_imem_wait;
    if (i_redirect) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = inflight_r;
      pop_s  = (count_r != {CNT_W{1'b0}}) && i_inst_ready;
    end
  end

  // Fetch PC, outstanding-request flag and the PC tag of the outstanding request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      tag_r      <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      // memory answers exactly one cycle after acceptance, so the flag lives one cycle
      inflight_r <= accept_s;
      if (accept_s) begin
        tag_r <= fetch_pc_r;
      end
      if (i_redirect) begin
        fetch_pc_r <= i_redirect_pc;
      end else if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP_C;
      end
    end
  end

  // Queue storage, pointers and occupancy; redirect empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(QDEPTH); i++) begin
        inst_mem_r[i] <= {INST_W{1'b0}};
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
      end
    end else if (i_redirect) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        inst_mem_r[wr_ptr_r] <= i_imem_rddata;
        pc_mem_r[wr_ptr_r]   <= tag_r;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Outputs are taken straight from state registers (no bypass from memory data)
  always_comb begin
    o_imem_addr  = fetch_pc_r;
    o_imem_rd    = issue_s;
    o_inst       = inst_mem_r[rd_ptr_r];
    o_inst_pc    = pc_mem_r[rd_ptr_r];
    o_inst_valid = (count_r != {CNT_W{1'b0}});
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] flush_cnt_r;
  logic [32:0] flush_sum_s;

  // Words lost on a redirect: everything queued plus the response arriving now
  always_comb begin
    flush_sum_s = {1'b0, flush_cnt_r} + 33'(count_r) + 33'(inflight_r);
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (accept_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (i_redirect) begin
        flush_cnt_r <= flush_sum_s[32] ? 32'hFFFF_FFFF : flush_sum_s[31:0];
      end
    end
  end

  // Counter outputs
  always_comb begin
    o_fetch_cnt = fetch_cnt_r;
    o_flush_cnt = flush_cnt_r;
  end
`else
  // Statistics not built: counters read zero
  always_comb begin
    o_fetch_cnt = 32'd0;
    o_flush_cnt = 32'd0;
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue: table-driven start-up vectors, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_fetch_prefetch_queue;

  localparam int QD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] o_imem_addr;
  logic        o_imem_rd;
  logic        i_imem_wait;
  logic [15:0] i_imem_rddata;
  logic [15:0] o_inst;
  logic [15:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_halt;
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_flush_cnt;

  fetch_prefetch_queue #(
    .ADDR_W(16), .INST_W(16), .QDEPTH(QD), .PC_STEP(2), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .reset(reset),
    .o_imem_addr(o_imem_addr), .o_imem_rd(o_imem_rd),
    .i_imem_wait(i_imem_wait), .i_imem_rddata(i_imem_rddata),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_inst_valid(o_inst_valid),
    .i_inst_ready(i_inst_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_halt(i_halt),
    .o_fetch_cnt(o_fetch_cnt), .o_flush_cnt(o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: queue of PCs whose words are in the FIFO
  logic [15:0] m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_tag;
  logic        m_pend;
  int          m_fetch;
  int          m_flush;

  // observations from the last cycle
  logic        obs_rd, obs_valid, popped;
  logic [15:0] obs_addr, obs_inst, obs_pc, popped_pc;
  logic [31:0] obs_fcnt, obs_flcnt;

  typedef struct {
    logic        ready;
    logic        imem_wait;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] pops[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 16'h0000;
    m_tag   = 16'h0000;
    m_pend  = 1'b0;
    m_fetch = 0;
    m_flush = 0;
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release after an edge
  task automatic do_reset();
    reset         = 1'b1;
    i_halt        = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_inst_ready  = 1'b0;
    i_imem_wait   = 1'b0;
    #1;
    check("rst_rd",    {31'd0, o_imem_rd},    32'd0);
    check("rst_addr",  {16'd0, o_imem_addr},  32'd0);
    check("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    check("rst_inst",  {16'd0, o_inst},       32'd0);
    check("rst_pc",    {16'd0, o_inst_pc},    32'd0);
    check("rst_fcnt",  o_fetch_cnt,           32'd0);
    check("rst_flcnt", o_flush_cnt,           32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_imem_rddata = 16'($urandom);
    model_reset();
  endtask

  // One clock cycle: apply inputs, compare against model, then advance model
  task automatic drive_cycle(input logic halt, input logic redir, input logic [15:0] rpc,
                             input logic rdy, input logic wt);
    logic exp_rd;
    logic m_acc;
    i_halt        = halt;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_inst_ready  = rdy;
    i_imem_wait   = wt;
    @(negedge clk);
    obs_rd    = o_imem_rd;
    obs_addr  = o_imem_addr;
    obs_valid = o_inst_valid;
    obs_inst  = o_inst;
    obs_pc    = o_inst_pc;
    obs_fcnt  = o_fetch_cnt;
    obs_flcnt = o_flush_cnt;
    exp_rd = !halt && !redir && ((m_q.size() + int'(m_pend)) < QD);
    check("rd",    {31'd0, obs_rd},    {31'd0, exp_rd});
    check("addr",  {16'd0, obs_addr},  {16'd0, m_pc});
    check("valid", {31'd0, obs_valid}, {31'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      check("inst_pc", {16'd0, obs_pc},   {16'd0, m_q[0]});
      check("inst",    {16'd0, obs_inst}, {16'd0, m_q[0] ^ 16'hA5A5});
    end
`ifdef FETCH_STATS_EN
    check("fetch_cnt", obs_fcnt,  32'(m_fetch));
    check("flush_cnt", obs_flcnt, 32'(m_flush));
`else
    check("fetch_cnt", obs_fcnt,  32'd0);
    check("flush_cnt", obs_flcnt, 32'd0);
`endif
    popped    = obs_valid && rdy && !redir;
    popped_pc = obs_pc;
    @(posedge clk);
    #1;
    // model update from the rules
    if (redir) begin
      m_flush += m_q.size() + int'(m_pend);
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = rpc;
    end else begin
      if (rdy && (m_q.size() > 0)) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_tag);
      m_acc = exp_rd && !wt;
      if (m_acc) begin
        m_fetch++;
        m_tag = m_pc;
        m_pc  = m_pc + 16'd2;
      end
      m_pend = m_acc;
    end
    // memory responder acts on what the DUT actually requested
    if (obs_rd && !wt) i_imem_rddata = obs_addr ^ 16'hA5A5;
    else               i_imem_rddata = 16'($urandom);
  endtask

  initial begin
    int n_acc;
    int old_pops;
    logic saw_rd;
    logic [31:0] flush_after;

    reset = 1'b1;
    i_halt = 1'b0; i_redirect = 1'b0; i_redirect_pc = 16'h0000;
    i_inst_ready = 1'b0; i_imem_wait = 1'b0; i_imem_rddata = 16'h0000;
    model_reset();
    @(posedge clk);
    #1;

    // start-up vectors: ready=1, wait=0
    vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0002};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0004};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 16'h0006};

    // test 1: latency and streaming after reset release
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, vecs[i].ready, vecs[i].imem_wait);
      check("t1_rd",    {31'd0, obs_rd},    {31'd0, vecs[i].exp_rd});
      check("t1_addr",  {16'd0, obs_addr},  {16'd0, vecs[i].exp_addr});
      check("t1_valid", {31'd0, obs_valid}, {31'd0, vecs[i].exp_valid});
      check("t1_pc",    {16'd0, obs_pc},    {16'd0, vecs[i].exp_pc});
    end

    // test 2: decode stalled fills exactly QDEPTH entries, then drains in order
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      if (obs_rd) n_acc++;
    end
    check("t2_accepts", 32'(n_acc), 32'd4);
    check("t2_rd_full", {31'd0, obs_rd}, 32'd0);
    pops.delete();
    saw_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      if (popped) pops.push_back(popped_pc);
      if (obs_rd) saw_rd = 1'b1;
    end
    check("t2_npops", {31'd0, (pops.size() >= 4)}, 32'd1);
    for (int i = 0; i < 4 && i < pops.size(); i++)
      check("t2_order", {16'd0, pops[i]}, 32'(2 * i));
    check("t2_resume", {31'd0, saw_rd}, 32'd1);

    // test 3: redirect with 3 queued words and one in flight
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
    check("t3_rd_in_t", {31'd0, obs_rd}, 32'd0);
    old_pops = 0;
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    flush_after = obs_flcnt;
    check("t3_valid_t1", {31'd0, obs_valid}, 32'd0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("t3_valid_t2", {31'd0, obs_valid}, 32'd0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("t3_valid_t3", {31'd0, obs_valid}, 32'd1);
    check("t3_pc_t3", {16'd0, obs_pc}, 32'h0100);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      if (popped && popped_pc < 16'h0100) old_pops++;
    end
    check("t3_old_pops", 32'(old_pops), 32'd0);
`ifdef FETCH_STATS_EN
    check("t3_flush_cnt", flush_after, 32'd4);
`else
    check("t3_flush_cnt", flush_after, 32'd0);
`endif

    // test 4: memory wait holds the address, no duplicate word
    do_reset();
    pops.delete();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      if (popped) pops.push_back(popped_pc);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      check("t4_addr_held", {16'd0, obs_addr}, 32'h0008);
      if (popped) pops.push_back(popped_pc);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      if (popped) pops.push_back(popped_pc);
    end
    check("t4_npops", {31'd0, (pops.size() >= 6)}, 32'd1);
    for (int i = 0; i < 6 && i < pops.size(); i++)
      check("t4_seq", {16'd0, pops[i]}, 32'(2 * i));

    // test 5: PC wraps past 0xFFFE
    do_reset();
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 16'hFFFC, 1'b1, 1'b0);
    pops.delete();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      if (popped) pops.push_back(popped_pc);
    end
    check("t5_npops", {31'd0, (pops.size() >= 3)}, 32'd1);
    if (pops.size() >= 3) begin
      check("t5_pc0", {16'd0, pops[0]}, 32'h0000_FFFC);
      check("t5_pc1", {16'd0, pops[1]}, 32'h0000_FFFE);
      check("t5_pc2", {16'd0, pops[2]}, 32'h0000_0000);
    end

    // test 6: halt with a request in flight, then reset mid-stream
    do_reset();
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("t6_rd_halt", {31'd0, obs_rd}, 32'd0);
    drive_cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("t6_rd_halt2", {31'd0, obs_rd}, 32'd0);
    check("t6_valid", {31'd0, obs_valid}, 32'd1);
    check("t6_pc", {16'd0, obs_pc}, 32'h0000);
    drive_cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("t6_rd_halt3", {31'd0, obs_rd}, 32'd0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("t6_rd_resume", {31'd0, obs_rd}, 32'd1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
